mode_sequencer: RTL and testbench

Front-panel controller for the watch/stopwatch/alarm display system.
- Debounces the mode and start push-buttons and reduces each to a one-cycle pulse.
- Runs the display-mode FSM and pre-empts it with an alarm-ring state.
- Drives the select and enable signals that choose which function owns the 7-segment display, plus the status LEDs.
- Sits between the raw board inputs and the watch/stopwatch/alarm datapaths and the display mux.

---
 rtl/mode_pkg.sv | 30 +++
 rtl/btn_debounce.sv | 54 +++++
 rtl/mode_sequencer.sv | 133 +++++++++++++
 tb/tb_mode_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mode_pkg.sv
// Shared state encoding, display-select codes and LED patterns for the front-panel sequencer.
package mode_pkg;

    typedef enum logic [1:0] {
        S_CLOCK = 2'b00,
        S_SW    = 2'b01,
        S_ASET  = 2'b10,
        S_RING  = 2'b11
    } state_t;

    localparam logic [1:0] DISP_WATCH = 2'b00;
    localparam logic [1:0] DISP_SW    = 2'b01;
    localparam logic [1:0] DISP_ALARM = 2'b10;

    localparam logic [7:0] LED_CLOCK = 8'h01;
    localparam logic [7:0] LED_SW    = 8'h02;
    localparam logic [7:0] LED_ASET  = 8'h04;
    localparam logic [7:0] LED_ON    = 8'hFF;
    localparam logic [7:0] LED_OFF   = 8'h00;

    // Mode-button rotation; S_RING never advances by mode press.
    function automatic state_t next_mode(input state_t s);
        case (s)
            S_CLOCK: next_mode = S_SW;
            S_SW:    next_mode = S_ASET;
            default: next_mode = S_CLOCK;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: 2-flop sync, stability counter, one-cycle press pulse on accepted 0->1 level.
// Latency raw edge -> press is 2+DEB_CYCLES cycles; no backpressure, releases emit nothing.
module btn_debounce #(
    parameter int DEB_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        press_d  = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // DEB_CYCLES consecutive differing samples: accept the new level.
            cnt_d    = '0;
            stable_d = sync2_q;
            press_d  = sync2_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/mode_sequencer.sv
// Front-panel display-mode FSM with alarm-ring pre-emption, ring timeout and LED blink.
// Outputs are Moore-decoded and change the cycle after the causing pulse; no backpressure.
module mode_sequencer
    import mode_pkg::*;
#(
    parameter int DEB_CYCLES  = 20,
    parameter int RING_CYCLES = 30000,
    parameter int BLINK_HALF  = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       start_btn,
    input  logic       alarm_hit,
    input  logic [9:0] keypad,
    output logic [1:0] disp_sel,
    output logic       alarm_set_mode,
    output logic       sw_start,
    output logic       ringing,
    output logic [7:0] led
);

    localparam int RW = (RING_CYCLES > 1) ? $clog2(RING_CYCLES) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [RW-1:0] RING_LAST  = RW'(RING_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic mode_press, start_press, key_pulse;
    logic key_any_q;

    state_t        state_q, state_d;
    state_t        ret_q, ret_d;
    logic [RW-1:0] ring_q, ring_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          phase_q, phase_d;
    logic          sw_start_q, sw_start_d;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode_deb (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (mode_btn),
        .press   (mode_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_start_deb (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (start_btn),
        .press   (start_press)
    );

    assign key_pulse = (|keypad) & ~key_any_q;

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        ring_d     = ring_q;
        blink_d    = blink_q;
        phase_d    = phase_q;
        sw_start_d = 1'b0;
        if (state_q == S_RING) begin
            // Any dismissing pulse is consumed here and has no further effect.
            if (mode_press || start_press || key_pulse || (ring_q == RING_LAST)) begin
                state_d = ret_q;
            end else begin
                ring_d = ring_q + RW'(1);
            end
            if (blink_q == BLINK_LAST) begin
                blink_d = '0;
                phase_d = ~phase_q;
            end else begin
                blink_d = blink_q + BW'(1);
            end
        end else begin
            if (alarm_hit) begin
                state_d = S_RING;
                ret_d   = state_q;
                ring_d  = '0;
                blink_d = '0;
                phase_d = 1'b1;
            end else if (mode_press) begin
                state_d = next_mode(state_q);
            end
            sw_start_d = (state_q == S_SW) && start_press;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_CLOCK;
            ret_q      <= S_CLOCK;
            ring_q     <= '0;
            blink_q    <= '0;
            phase_q    <= 1'b0;
            sw_start_q <= 1'b0;
            key_any_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            ring_q     <= ring_d;
            blink_q    <= blink_d;
            phase_q    <= phase_d;
            sw_start_q <= sw_start_d;
            key_any_q  <= |keypad;
        end
    end

    always_comb begin
        disp_sel       = DISP_WATCH;
        alarm_set_mode = 1'b0;
        ringing        = 1'b0;
        led            = LED_CLOCK;
        case (state_q)
            S_SW: begin
                disp_sel = DISP_SW;
                led      = LED_SW;
            end
            S_ASET: begin
                disp_sel       = DISP_ALARM;
                alarm_set_mode = 1'b1;
                led            = LED_ASET;
            end
            S_RING: begin
                ringing = 1'b1;
                led     = phase_q ? LED_ON : LED_OFF;
            end
            default: ;
        endcase
    end

    assign sw_start = sw_start_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer with short debounce/ring/blink parameters.
module tb_mode_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode_btn, start_btn, alarm_hit;
    logic [9:0] keypad;
    logic [1:0] disp_sel;
    logic       alarm_set_mode, sw_start, ringing;
    logic [7:0] led;

    int n_checks = 0;
    int n_errors = 0;

    mode_sequencer #(
        .DEB_CYCLES  (4),
        .RING_CYCLES (50),
        .BLINK_HALF  (5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mode_btn       (mode_btn),
        .start_btn      (start_btn),
        .alarm_hit      (alarm_hit),
        .keypad         (keypad),
        .disp_sel       (disp_sel),
        .alarm_set_mode (alarm_set_mode),
        .sw_start       (sw_start),
        .ringing        (ringing),
        .led            (led)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_mode(input string tag, input logic [1:0] d, input logic [7:0] l, input logic a);
        check_val({tag, "_disp"}, 32'(disp_sel), 32'(d));
        check_val({tag, "_led"},  32'(led),      32'(l));
        check_val({tag, "_aset"}, 32'(alarm_set_mode), 32'(a));
    endtask

    // Clean mode press: unchanged at 2+DEB cycles, new mode one cycle later.
    task automatic press_mode(input string tag, input logic [1:0] d_old, input logic [1:0] d_new,
                              input logic [7:0] l_new, input logic a_new);
        mode_btn = 1'b1;
        tick(6);
        check_val({tag, "_early"}, 32'(disp_sel), 32'(d_old));
        tick(1);
        check_mode(tag, d_new, l_new, a_new);
        mode_btn = 1'b0;
        tick(10);
        check_val({tag, "_release"}, 32'(disp_sel), 32'(d_new));
    endtask

    // Hold start long enough to debounce, counting sw_start pulses.
    task automatic press_start_count(output int pulses);
        pulses = 0;
        start_btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (sw_start) pulses++;
        end
        start_btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (sw_start) pulses++;
        end
    endtask

    task automatic alarm_pulse();
        alarm_hit = 1'b1;
        tick(1);
        alarm_hit = 1'b0;
    endtask

    int pulses;

    initial begin
        rst = 1'b1; mode_btn = 1'b0; start_btn = 1'b0; alarm_hit = 1'b0; keypad = '0;
        tick(3);
        rst = 1'b0;
        check_mode("reset", 2'b00, 8'h01, 1'b0);
        check_val("reset_ring", 32'(ringing), 32'd0);
        check_val("reset_sw", 32'(sw_start), 32'd0);

        // 1: full mode rotation
        press_mode("m1", 2'b00, 2'b01, 8'h02, 1'b0);
        press_mode("m2", 2'b01, 2'b10, 8'h04, 1'b1);
        press_mode("m3", 2'b10, 2'b00, 8'h01, 1'b0);

        // 2: bouncing button then a long hold gives one advance
        for (int i = 0; i < 5; i++) begin
            mode_btn = 1'b1; tick(2);
            mode_btn = 1'b0; tick(2);
        end
        check_val("bounce_none", 32'(disp_sel), 32'd0);
        mode_btn = 1'b1;
        tick(30);
        check_mode("bounce_hold", 2'b01, 8'h02, 1'b0);
        mode_btn = 1'b0;
        tick(15);
        check_val("bounce_release", 32'(disp_sel), 32'd1);

        // 3: start in S_SW pulses once, with exact timing
        start_btn = 1'b1;
        tick(6);
        check_val("start_early", 32'(sw_start), 32'd0);
        tick(1);
        check_val("start_pulse", 32'(sw_start), 32'd1);
        tick(1);
        check_val("start_width", 32'(sw_start), 32'd0);
        start_btn = 1'b0;
        tick(10);
        press_start_count(pulses);
        check_val("start_sw_count", 32'(pulses), 32'd1);
        check_val("start_sw_mode", 32'(disp_sel), 32'd1);
        press_mode("to_aset", 2'b01, 2'b10, 8'h04, 1'b1);
        press_mode("to_clock", 2'b10, 2'b00, 8'h01, 1'b0);
        press_start_count(pulses);
        check_val("start_clock_count", 32'(pulses), 32'd0);
        press_mode("to_sw", 2'b00, 2'b01, 8'h02, 1'b0);

        // 4: ring from S_SW, blink pattern, timeout back to S_SW
        alarm_pulse();
        check_val("ring_on", 32'(ringing), 32'd1);
        check_val("ring_disp", 32'(disp_sel), 32'd0);
        check_val("blink_0", 32'(led), 32'hFF);
        tick(4);
        check_val("blink_4", 32'(led), 32'hFF);
        tick(1);
        check_val("blink_5", 32'(led), 32'h00);
        tick(4);
        check_val("blink_9", 32'(led), 32'h00);
        tick(1);
        check_val("blink_10", 32'(led), 32'hFF);
        tick(39);
        check_val("timeout_last", 32'(ringing), 32'd1);
        tick(1);
        check_val("timeout_ring", 32'(ringing), 32'd0);
        check_mode("timeout", 2'b01, 8'h02, 1'b0);

        // 5a: keypad dismisses
        alarm_pulse();
        tick(3);
        keypad = 10'h004;
        tick(1);
        check_val("key_ring", 32'(ringing), 32'd0);
        check_mode("key", 2'b01, 8'h02, 1'b0);
        keypad = '0;
        tick(2);
        // 5b: second alarm_hit does not restart the timer
        alarm_pulse();
        tick(20);
        alarm_pulse();
        check_val("rehit_ring", 32'(ringing), 32'd1);
        tick(28);
        check_val("rehit_last", 32'(ringing), 32'd1);
        tick(1);
        check_val("rehit_exit", 32'(ringing), 32'd0);
        check_val("rehit_disp", 32'(disp_sel), 32'd1);
        // 5c: mode press dismisses without advancing
        alarm_pulse();
        tick(3);
        mode_btn = 1'b1;
        tick(6);
        check_val("mdis_early", 32'(ringing), 32'd1);
        tick(1);
        check_val("mdis_ring", 32'(ringing), 32'd0);
        check_val("mdis_disp", 32'(disp_sel), 32'd1);
        mode_btn = 1'b0;
        tick(10);
        check_val("mdis_after", 32'(disp_sel), 32'd1);

        // 6: alarm coincident with mode pulse in S_ASET
        press_mode("to_aset2", 2'b01, 2'b10, 8'h04, 1'b1);
        mode_btn = 1'b1;
        tick(6);
        alarm_hit = 1'b1;
        tick(1);
        alarm_hit = 1'b0;
        check_val("coinc_ring", 32'(ringing), 32'd1);
        check_val("coinc_aset", 32'(alarm_set_mode), 32'd0);
        mode_btn = 1'b0;
        tick(10);
        check_val("coinc_hold", 32'(ringing), 32'd1);
        keypad = 10'h200;
        tick(1);
        check_mode("coinc_ret", 2'b10, 8'h04, 1'b1);
        check_val("coinc_ret_ring", 32'(ringing), 32'd0);
        keypad = '0;
        tick(2);
        // reset mid-ring
        alarm_pulse();
        tick(10);
        rst = 1'b1;
        tick(1);
        check_mode("rst_ring", 2'b00, 8'h01, 1'b0);
        check_val("rst_ring_ring", 32'(ringing), 32'd0);
        rst = 1'b0;
        // reset mid-debounce
        mode_btn = 1'b1;
        tick(4);
        rst = 1'b1;
        mode_btn = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(12);
        check_val("rst_deb_disp", 32'(disp_sel), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
